// File: rtl/proc_mem.sv
// Dual-port word memory answering TinyRV1 fetch and data requests, with a
// test-harness loader port, sticky first-fault capture and saturating access counters.
module proc_mem #(
  parameter int p_num_words = 256,
  parameter int p_cnt_width = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  input  logic        ld_val,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        err,
  output logic        err_src,
  output logic [31:0] err_addr,
  output logic [31:0] imem_count,
  output logic [31:0] dmem_rd_count,
  output logic [31:0] dmem_wr_count
);

  localparam int aw = $clog2(p_num_words);
  localparam logic [31:0] byte_limit = 32'(4 * p_num_words);

  logic [31:0] mem [p_num_words];

  logic            i_legal, d_legal, ld_legal;
  logic [aw-1:0]   i_idx, d_idx, ld_idx;
  logic            i_acc, d_rd_acc, d_wr_acc, i_fault, d_fault;
  logic [p_cnt_width-1:0] imem_cnt, rd_cnt, wr_cnt;

  assign i_legal  = (imemreq_addr[1:0] == 2'b00) && (imemreq_addr < byte_limit);
  assign d_legal  = (dmemreq_addr[1:0] == 2'b00) && (dmemreq_addr < byte_limit);
  assign ld_legal = (ld_addr[1:0] == 2'b00) && (ld_addr < byte_limit);

  assign i_idx  = imemreq_addr[aw+1:2];
  assign d_idx  = dmemreq_addr[aw+1:2];
  assign ld_idx = ld_addr[aw+1:2];

  assign i_acc    = imemreq_val && i_legal;
  assign d_rd_acc = dmemreq_val && !dmemreq_type && d_legal;
  assign d_wr_acc = dmemreq_val && dmemreq_type && d_legal;
  assign i_fault  = imemreq_val && !i_legal;
  assign d_fault  = dmemreq_val && !d_legal;

  // Reads see the array as it stood before this cycle's edge.
  assign imemresp_data  = i_acc    ? mem[i_idx] : 32'h0;
  assign dmemresp_rdata = d_rd_acc ? mem[d_idx] : 32'h0;

  // NOTE: the array has no reset branch; contents must survive rst, and a
  // reset here would also stop it mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (d_wr_acc && !rst)
      mem[d_idx] <= dmemreq_wdata;
    // Loader update is scheduled last so it wins a same-word collision.
    if (ld_val && ld_legal)
      mem[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_src  <= 1'b0;
      err_addr <= 32'h0;
    end else if (!err) begin
      if (i_fault) begin
        err      <= 1'b1;
        err_src  <= 1'b0;
        err_addr <= imemreq_addr;
      end else if (d_fault) begin
        err      <= 1'b1;
        err_src  <= 1'b1;
        err_addr <= dmemreq_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_cnt <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      if (i_acc && (imem_cnt != '1))
        imem_cnt <= imem_cnt + p_cnt_width'(1);
      if (d_rd_acc && (rd_cnt != '1))
        rd_cnt <= rd_cnt + p_cnt_width'(1);
      if (d_wr_acc && (wr_cnt != '1))
        wr_cnt <= wr_cnt + p_cnt_width'(1);
    end
  end

  assign imem_count    = 32'(imem_cnt);
  assign dmem_rd_count = 32'(rd_cnt);
  assign dmem_wr_count = 32'(wr_cnt);

endmodule

// File: tb/tb_proc_mem.sv
// Scoreboard bench for proc_mem: a full-width instance plus a 2-bit counter
// instance sharing stimulus, both checked against a bench-side memory model.
module tb_proc_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val, dmemreq_val, dmemreq_type, ld_val;
  logic [31:0] imemreq_addr, dmemreq_addr, dmemreq_wdata, ld_addr, ld_data;

  logic [31:0] imemresp_data, dmemresp_rdata, err_addr;
  logic [31:0] imem_count, dmem_rd_count, dmem_wr_count;
  logic        err, err_src;

  logic [31:0] s_imemresp_data, s_dmemresp_rdata, s_err_addr;
  logic [31:0] s_imem_count, s_dmem_rd_count, s_dmem_wr_count;
  logic        s_err, s_err_src;

  always #5 clk = ~clk;

  proc_mem #(.p_num_words(256)) u_dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
    .ld_val(ld_val), .ld_addr(ld_addr), .ld_data(ld_data),
    .err(err), .err_src(err_src), .err_addr(err_addr),
    .imem_count(imem_count), .dmem_rd_count(dmem_rd_count), .dmem_wr_count(dmem_wr_count)
  );

  proc_mem #(.p_num_words(256), .p_cnt_width(2)) u_sat (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(s_imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(s_dmemresp_rdata),
    .ld_val(ld_val), .ld_addr(ld_addr), .ld_data(ld_data),
    .err(s_err), .err_src(s_err_src), .err_addr(s_err_addr),
    .imem_count(s_imem_count), .dmem_rd_count(s_dmem_rd_count), .dmem_wr_count(s_dmem_wr_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [31:0] mem_m [256];
  logic [31:0] m_imem = 0, m_rd = 0, m_wr = 0;
  logic [31:0] s_imem = 0, s_rd = 0, s_wr = 0;
  logic        m_err = 0, m_src = 0;
  logic [31:0] m_addr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic [31:0] max);
    return (c == max) ? c : c + 1;
  endfunction

  // One clock: predict reads, compare at negedge, advance the model, compare state after the edge.
  task automatic step();
    logic [31:0] e_i, e_d;
    bit il, dl, ll, i_acc, rd_acc, wr_acc;
    il = is_legal(imemreq_addr);
    dl = is_legal(dmemreq_addr);
    ll = is_legal(ld_addr);
    i_acc  = imemreq_val && il;
    rd_acc = dmemreq_val && !dmemreq_type && dl;
    wr_acc = dmemreq_val && dmemreq_type && dl;
    e_i = i_acc  ? mem_m[imemreq_addr[9:2]] : 32'h0;
    e_d = rd_acc ? mem_m[dmemreq_addr[9:2]] : 32'h0;
    sb_push("imem_rdata", e_i);
    sb_push("dmem_rdata", e_d);
    sb_push("sat_imem_rdata", e_i);
    sb_push("sat_dmem_rdata", e_d);
    @(negedge clk);
    sb_pop_check(imemresp_data);
    sb_pop_check(dmemresp_rdata);
    sb_pop_check(s_imemresp_data);
    sb_pop_check(s_dmemresp_rdata);

    if (!rst && wr_acc) mem_m[dmemreq_addr[9:2]] = dmemreq_wdata;
    if (ld_val && ll)   mem_m[ld_addr[9:2]] = ld_data;
    if (rst) begin
      m_imem = 0; m_rd = 0; m_wr = 0;
      s_imem = 0; s_rd = 0; s_wr = 0;
      m_err = 0; m_src = 0; m_addr = 0;
    end else begin
      if (i_acc)  begin m_imem = sat_inc(m_imem, 32'hFFFF_FFFF); s_imem = sat_inc(s_imem, 3); end
      if (rd_acc) begin m_rd   = sat_inc(m_rd,   32'hFFFF_FFFF); s_rd   = sat_inc(s_rd,   3); end
      if (wr_acc) begin m_wr   = sat_inc(m_wr,   32'hFFFF_FFFF); s_wr   = sat_inc(s_wr,   3); end
      if (!m_err) begin
        if (imemreq_val && !il) begin
          m_err = 1; m_src = 0; m_addr = imemreq_addr;
        end else if (dmemreq_val && !dl) begin
          m_err = 1; m_src = 1; m_addr = dmemreq_addr;
        end
      end
    end

    sb_push("imem_count", m_imem);
    sb_push("dmem_rd_count", m_rd);
    sb_push("dmem_wr_count", m_wr);
    sb_push("err", 32'(m_err));
    sb_push("err_src", 32'(m_src));
    sb_push("err_addr", m_addr);
    sb_push("sat_imem_count", s_imem);
    sb_push("sat_dmem_rd_count", s_rd);
    sb_push("sat_dmem_wr_count", s_wr);
    sb_push("sat_err_addr", m_addr);
    @(posedge clk);
    #1;
    sb_pop_check(imem_count);
    sb_pop_check(dmem_rd_count);
    sb_pop_check(dmem_wr_count);
    sb_pop_check(32'(err));
    sb_pop_check(32'(err_src));
    sb_pop_check(err_addr);
    sb_pop_check(s_imem_count);
    sb_pop_check(s_dmem_rd_count);
    sb_pop_check(s_dmem_wr_count);
    sb_pop_check(s_err_addr);
  endtask

  task automatic idle();
    imemreq_val = 0; imemreq_addr = 0;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
    ld_val = 0; ld_addr = 0; ld_data = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    idle();
    ld_val = 1; ld_addr = a; ld_data = d;
    step();
  endtask

  task automatic fetch(input logic [31:0] a);
    idle();
    imemreq_val = 1; imemreq_addr = a;
    step();
  endtask

  task automatic dread(input logic [31:0] a);
    idle();
    dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = a;
    step();
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d);
    idle();
    dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = a; dmemreq_wdata = d;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    idle();
    step();
    step();

    // Preload under reset, including words used later
    load(32'h0,   32'h0050_0093);
    load(32'h4,   32'h0010_0113);
    load(32'h40,  32'h1234_5678);
    load(32'h80,  32'hCAFE_0080);
    load(32'h100, 32'h0BAD_0100);
    fetch(32'h0);                       // read during reset follows normal rules, not counted
    check("fetch_in_reset_count", imem_count, 32'h0);

    rst = 0;
    fetch(32'h0);
    fetch(32'h4);
    check("imem_count_after_two", imem_count, 32'd2);

    // Same-cycle fetch of a word being written sees the old value
    idle();
    dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h100; dmemreq_wdata = 32'hDEAD_BEEF;
    imemreq_val = 1; imemreq_addr = 32'h100;
    step();
    dread(32'h100);
    check("dmem_rdata_new", dmemresp_rdata, 32'hDEAD_BEEF);
    dread(32'h100);
    check("dmem_wr_count_1", dmem_wr_count, 32'd1);
    check("dmem_rd_count_2", dmem_rd_count, 32'd2);

    // Loader beats data write on a collision
    idle();
    ld_val = 1; ld_addr = 32'h20; ld_data = 32'h1111;
    dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h20; dmemreq_wdata = 32'h2222;
    step();
    dread(32'h20);
    check("collision_loader_wins", dmemresp_rdata, 32'h1111);

    // Reset mid-run suppresses the data write and clears state
    rst = 1;
    dwrite(32'h40, 32'h55);
    rst = 0;
    check("reset_clears_rd_count", dmem_rd_count, 32'h0);
    dread(32'h40);
    check("write_in_reset_dropped", dmemresp_rdata, 32'h1234_5678);
    fetch(32'h80);
    check("preload_survives_reset", imemresp_data, 32'hCAFE_0080);

    // Illegal loader write is dropped and does not fault
    load(32'h1002, 32'hFFFF_FFFF);
    check("ld_illegal_no_err", 32'(err), 32'h0);

    // Faults: first fault sticks
    dread(32'h102);
    check("fault_err", 32'(err), 32'h1);
    check("fault_src_dmem", 32'(err_src), 32'h1);
    check("fault_addr", err_addr, 32'h102);
    fetch(32'h400);
    check("fault_addr_sticky", err_addr, 32'h102);
    dwrite(32'h800, 32'h7777);          // illegal write dropped, not counted

    rst = 1;
    step();
    rst = 0;
    idle();
    imemreq_val = 1; imemreq_addr = 32'h3;
    dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h7;
    step();
    check("dual_fault_src_imem", 32'(err_src), 32'h0);
    check("dual_fault_addr", err_addr, 32'h3);

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) dread(32'h100);
    check("sat_rd_count_holds", s_dmem_rd_count, 32'd3);
    check("full_rd_count", dmem_rd_count, 32'd5);
    for (int i = 0; i < 4; i++) dwrite(32'h30 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) fetch(32'h30 + 32'(i * 4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_mem.md
# proc_mem

Dual-port memory responder serving the TinyRV1 processor's instruction-fetch and data-access request ports. Instruction and data reads return data in the same cycle; data and loader writes commit on the clock edge. A test-harness loader port preloads programs. Sticky fault capture and access counters support verification and tracing.

## Interface

- p_num_words, 256: memory depth in 32-bit words; power of two, 16 to 65536.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imemreq_val  in  1  instruction fetch request valid.
- imemreq_addr  in  32  fetch byte address.
- imemresp_data  out  32  fetch data, combinational.
- dmemreq_val  in  1  data request valid.
- dmemreq_type  in  1  0 = read, 1 = write.
- dmemreq_addr  in  32  data byte address.
- dmemreq_wdata  in  32  write data.
- dmemresp_rdata  out  32  read data, combinational.
- ld_val  in  1  loader write valid.
- ld_addr  in  32  loader byte address.
- ld_data  in  32  loader write data.
- err  out  1  sticky fault flag.
- err_src  out  1  source of the first fault: 0 = imem, 1 = dmem.
- err_addr  out  32  byte address of the first fault.
- imem_count  out  32  count of accepted fetches.
- dmem_rd_count  out  32  count of accepted data reads.
- dmem_wr_count  out  32  count of accepted data writes.

## Operation

- Word index = addr[log2(p_num_words)+1:2].
- An access is legal when addr[1:0] == 2'b00 and addr < 4*p_num_words. Otherwise it is a fault.
- Fetch: imemresp_data = mem[index] if imemreq_val and the access is legal; otherwise 32'h0.
- Data read: dmemresp_rdata = mem[index] if dmemreq_val, type=0, and the access is legal; otherwise 32'h0.
  - dmemresp_rdata is also 0 for writes.
- Data write: with dmemreq_val, type=1, a legal access, and rst low, mem[index] <= wdata at the edge.
  - Illegal writes are dropped.
- Loader write: with ld_val and a legal access, mem[index] <= ld_data. This works regardless of rst.
  - Illegal loader addresses are dropped silently and do not set err.
- Collision: a loader write and a data write to the same word in the same cycle resolve to the loader value.
- Same-cycle read of a word being written returns the old value. The new value is visible the next cycle.
- The memory array is not reset. Contents persist across rst.
- Faults: a valid illegal imem or dmem request with err=0 sets err and captures err_src and err_addr.
  - If both ports fault in the same cycle, imem wins (err_src=0).
  - After err=1, later faults do not change err, err_src or err_addr.
- Counters: each increments by 1 per cycle with a valid, legal request of its kind.
  - Counters saturate at 32'hFFFF_FFFF.
  - Faulting requests and loader writes are not counted.
  - Counters do not increment while rst is high.

## Timing

- Read latency is 0 cycles, combinational from address, valid and array state.
- Write latency is 1 edge.
- There is no backpressure. Every valid request completes in its cycle.
- Reset values: err=0, err_src=0, err_addr=0, all counters 0. These take effect at the first edge with rst high.
- Read data outputs are combinational and not reset. They follow the rules above during reset.
- Reset mid-operation:
  - A data write presented in a rst-high cycle is suppressed.
  - Memory contents are unchanged.
  - Counters and fault state clear on that edge.
- Only clk/rst-qualified edges change state. There are no asynchronous paths.

## Test plan

- Preload via loader under rst, then fetch: ld 0x0→0x00500093, 0x4→0x00100113; release rst; fetch 0x0 and 0x4 → imemresp_data = 0x00500093, then 0x00100113; imem_count = 2.
- Write then read: dmem write 0x100←0xDEADBEEF. A read of 0x100 in the same cycle returns the old value; the next cycle returns 0xDEADBEEF. dmem_wr_count=1, dmem_rd_count=2.
- Collision: in one cycle, ld 0x20←0x1111 and dmem write 0x20←0x2222 → the following read of 0x20 returns 0x1111.
- Faults: dmem read at 0x102 → rdata=0, err=1, err_src=1, err_addr=0x102. Then an imem fetch at 0x400 (p_num_words=256) returns 0 with err_addr unchanged. Simultaneous imem 0x3 and dmem 0x7 faults after reset → err_src=0, err_addr=0x3.
- Reset mid-run: dmem write 0x40←0x55 with rst high → the read after reset returns the prior value. Counters and err read 0 after the edge. A word preloaded before reset is intact.
- Saturation: force dmem_rd_count to 0xFFFF_FFFE (or a reduced-width build), issue 3 reads → the count holds at 0xFFFF_FFFF.
